ysyx_core_seq: RTL and testbench

- Multi-cycle control FSM that sequences the core: PC, IFU fetch, IDU/EXU datapath and LSU memory access.
- Replaces the implicit single-cycle "every clk edge" commit. PC update, register-file write and memory access happen only when the handshaking memory interfaces complete.
- Sits beside the datapath top. It gates PC write-enable and RF write-enable and owns the fetch and load/store valid/ready handshakes.

---
 rtl/ysyx_seq_pkg.sv | 27 ++
 rtl/ysyx_seq_timeout.sv | 37 +++
 rtl/ysyx_core_seq.sv | 162 ++++++++++++++++
 tb/tb_ysyx_core_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_seq_pkg.sv
// ysyx_seq_pkg
//   Shared definitions for the multi-cycle core sequencer:
//   - seq_state_t : FSM state encoding, also exported on the debug port state_o
//   - DEFAULT_RESET_PC / NOP_INST : reset values for the PC and the IR
//   - is_wait_state() : true for states that wait on an external handshake
package ysyx_seq_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // HALT and ERR share encoding 7; the halted and bus_err flags tell them apart.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_IWAIT    = 3'd2,
    S_EXEC     = 3'd3,
    S_MREQ     = 3'd4,
    S_MWAIT    = 3'd5,
    S_WB       = 3'd6,
    S_HALT_ERR = 3'd7
  } seq_state_t;

  function automatic logic is_wait_state(input seq_state_t s);
    return (s == S_FETCH) || (s == S_IWAIT) || (s == S_MREQ) || (s == S_MWAIT);
  endfunction

endpackage

// File: rtl/ysyx_seq_timeout.sv
// ysyx_seq_timeout
//   Handshake timeout counter for the core sequencer.
//   Ports:
//     clk    in  core clock
//     rst    in  asynchronous active-low reset
//     clr    in  clear the count (state entry)
//     en     in  count one more cycle spent waiting without completion
//     expire out the cycle being counted now is the TIMEOUT-th one
module ysyx_seq_timeout #(
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TMO_W-1:0] count;

  // Count holds the number of earlier incomplete cycles in the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TMO_W'(1);
    end
  end

  // Independent of en so the FSM can decide completion-versus-error itself
  // without a combinational loop; completion in this cycle takes priority.
  assign expire = (count == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_core_seq.sv
// ysyx_core_seq
//   Multi-cycle control FSM sequencing fetch, execute, memory access and
//   write-back. PC and register-file writes only happen in WB, after the
//   fetch (and for loads/stores the LSU) handshakes have completed.
//   Ports:
//     clk, rst                     clock, asynchronous active-low reset
//     pc / next_pc                 PC register / PC candidate from EXU
//     ifu_req_valid/ifu_req_ready  fetch request handshake (address = pc)
//     ifu_resp_valid/ifu_resp_ready, ifu_rdata  fetch response handshake
//     inst                         instruction register driving IDU/EXU
//     is_load/is_store/is_ebreak/rf_wr_en_dec  IDU decode results
//     lsu_req_valid/lsu_req_ready, lsu_resp_valid  load/store handshake
//     pc_we, rf_wr_en              commit strobes (WB only)
//     halted, bus_err, state_o     status and debug state
//   Optional feature: define YSYX_CORE_SEQ_PERF_EN to add the perf_cycle and
//   perf_instret 64-bit counters as extra outputs.
module ysyx_core_seq
  import ysyx_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 255,
  parameter int          TMO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  output logic        ifu_resp_ready,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_ebreak,
  input  logic        rf_wr_en_dec,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic        pc_we,
  output logic        rf_wr_en,
  output logic        halted,
  output logic        bus_err,
  output logic [2:0]  state_o
`ifdef YSYX_CORE_SEQ_PERF_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
`endif
);

  seq_state_t state, state_next;
  logic       wait_done;
  logic       tmo_clr, tmo_en, tmo_expire;

  // The handshake that ends the current wait state, if any.
  assign wait_done = ((state == S_FETCH) && ifu_req_ready)  ||
                     ((state == S_IWAIT) && ifu_resp_valid) ||
                     ((state == S_MREQ)  && lsu_req_ready)  ||
                     ((state == S_MWAIT) && lsu_resp_valid);

  assign tmo_clr = (state_next != state);
  assign tmo_en  = is_wait_state(state) && !wait_done;

  ysyx_seq_timeout #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Next-state and strobe decode; every strobe defaults low so that only the
  // owning state can raise it.
  always_comb begin
    state_next     = state;
    ifu_req_valid  = 1'b0;
    ifu_resp_ready = 1'b0;
    lsu_req_valid  = 1'b0;
    pc_we          = 1'b0;
    rf_wr_en       = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready)   state_next = S_IWAIT;
        else if (tmo_expire) state_next = S_HALT_ERR;
      end
      S_IWAIT: begin
        ifu_resp_ready = 1'b1;
        if (ifu_resp_valid)  state_next = S_EXEC;
        else if (tmo_expire) state_next = S_HALT_ERR;
      end
      S_EXEC: begin
        if (is_ebreak)                state_next = S_WB;
        else if (is_load || is_store) state_next = S_MREQ;
        else                          state_next = S_WB;
      end
      S_MREQ: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready)   state_next = S_MWAIT;
        else if (tmo_expire) state_next = S_HALT_ERR;
      end
      S_MWAIT: begin
        if (lsu_resp_valid)  state_next = S_WB;
        else if (tmo_expire) state_next = S_HALT_ERR;
      end
      S_WB: begin
        // ebreak retires without moving the PC.
        pc_we      = !is_ebreak;
        rf_wr_en   = rf_wr_en_dec && !is_store;
        state_next = is_ebreak ? S_HALT_ERR : S_FETCH;
      end
      S_HALT_ERR: state_next = S_HALT_ERR;
      default:    state_next = S_HALT_ERR;
    endcase
  end

  // State register plus the sticky flags that distinguish HALT from ERR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      halted  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == S_WB) && is_ebreak) halted  <= 1'b1;
      if (tmo_en && tmo_expire)         bus_err <= 1'b1;
    end
  end

  // PC commits on the WB strobe; the IR only loads on an accepted response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc   <= RESET_PC;
      inst <= NOP_INST;
    end else begin
      if (pc_we) pc <= next_pc;
      if ((state == S_IWAIT) && ifu_resp_valid) inst <= ifu_rdata;
    end
  end

  assign state_o = state;

`ifdef YSYX_CORE_SEQ_PERF_EN
  // Cycles spent doing work and instructions retired (ebreak included).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycle   <= 64'd0;
      perf_instret <= 64'd0;
    end else begin
      if ((state != S_IDLE) && (state != S_HALT_ERR)) perf_cycle <= perf_cycle + 64'd1;
      if (state == S_WB) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_core_seq.sv
// tb_ysyx_core_seq
//   Self-checking bench for ysyx_core_seq. Each instruction is described by
//   its kind and the wait cycles of each handshake; the bench drives a
//   cycle schedule from those numbers and checks every output each cycle.
module tb_ysyx_core_seq;

  localparam int          TMO     = 4;
  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          K_ALU   = 0;
  localparam int          K_LOAD  = 1;
  localparam int          K_STORE = 2;
  localparam int          K_EBRK  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, next_pc, ifu_rdata, inst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic        is_load, is_store, is_ebreak, rf_wr_en_dec;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic        pc_we, rf_wr_en, halted, bus_err;
  logic [2:0]  state_o;
`ifdef YSYX_CORE_SEQ_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] model_pc, model_inst;
  bit          model_halted, model_err;

  int cyc, wb_seen, rf_cnt, pcwe_cnt, lsuv_cnt;

  typedef struct {
    int          kind, da, dr, la, lr;
    bit          rf_dec, junk;
    logic [31:0] npc, rdata;
    int          e_wb, e_rf, e_pcwe, e_lsuv;
  } vec_t;

  ysyx_core_seq #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO),
    .TMO_W    (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .next_pc        (next_pc),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_rdata      (ifu_rdata),
    .inst           (inst),
    .is_load        (is_load),
    .is_store       (is_store),
    .is_ebreak      (is_ebreak),
    .rf_wr_en_dec   (rf_wr_en_dec),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .pc_we          (pc_we),
    .rf_wr_en       (rf_wr_en),
    .halted         (halted),
    .bus_err        (bus_err),
    .state_o        (state_o)
`ifdef YSYX_CORE_SEQ_PERF_EN
    ,
    .perf_cycle     (perf_cycle),
    .perf_instret   (perf_instret)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Guards against a stuck simulation.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rq_rdy, input logic rs_vld, input logic [31:0] rdata,
                               input logic l_rdy, input logic l_rsp);
    ifu_req_ready  = rq_rdy;
    ifu_resp_valid = rs_vld;
    ifu_rdata      = rdata;
    lsu_req_ready  = l_rdy;
    lsu_resp_valid = l_rsp;
  endtask

  task automatic scrambleDecode();
    is_load      = 1'($urandom);
    is_store     = 1'($urandom);
    is_ebreak    = 1'($urandom);
    rf_wr_en_dec = 1'($urandom);
    next_pc      = $urandom;
  endtask

  task automatic setDecode(input int kind, input bit rf_dec, input logic [31:0] npc);
    is_load      = (kind == K_LOAD);
    is_store     = (kind == K_STORE);
    is_ebreak    = (kind == K_EBRK);
    rf_wr_en_dec = rf_dec;
    next_pc      = npc;
  endtask

  // Compare all outputs at the falling edge, tally strobes, advance one cycle.
  task automatic checkOutput(input string name, input bit rv, input bit rr, input bit lv,
                             input bit pw, input bit rw, input int st = -1);
    logic [70:0] actv, expv;
    @(negedge clk);
    actv = {ifu_req_valid, ifu_resp_ready, lsu_req_valid, pc_we, rf_wr_en, halted, bus_err, pc, inst};
    expv = {rv, rr, lv, pw, rw, model_halted, model_err, model_pc, model_inst};
    checks++;
    if (actv !== expv) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, actv, expv);
    end
    if (st >= 0) begin
      checks++;
      if (state_o !== 3'(st)) begin
        failures++;
        $display("[TB] FAIL %s_state actual=%0d required=%0d", name, state_o, st);
      end
    end
    if (state_o == 3'd6 && wb_seen == 0) wb_seen = cyc + 1;
    if (rf_wr_en === 1'b1) rf_cnt++;
    if (pc_we === 1'b1) pcwe_cnt++;
    if (lsu_req_valid === 1'b1) lsuv_cnt++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounts(input string name, input int e_wb, input int e_rf,
                             input int e_pcwe, input int e_lsuv);
    checks++;
    if (wb_seen != e_wb || rf_cnt != e_rf || pcwe_cnt != e_pcwe || lsuv_cnt != e_lsuv) begin
      failures++;
      $display("[TB] FAIL %s actual wb=%0d rf=%0d pcwe=%0d lsuv=%0d required wb=%0d rf=%0d pcwe=%0d lsuv=%0d",
               name, wb_seen, rf_cnt, pcwe_cnt, lsuv_cnt, e_wb, e_rf, e_pcwe, e_lsuv);
    end
  endtask

  task automatic clearTally();
    cyc = 0; wb_seen = 0; rf_cnt = 0; pcwe_cnt = 0; lsuv_cnt = 0;
  endtask

  // HALT/ERR: nothing may move while the IFU side keeps poking the core.
  task automatic checkStopped(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      scrambleDecode();
      applyStimulus(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      checkOutput(name, 0, 0, 0, 0, 0, 7);
    end
  endtask

  task automatic applyReset();
    rst = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0);
    setDecode(K_ALU, 0, 32'h0);
    model_pc = RST_PC; model_inst = NOP; model_halted = 0; model_err = 0;
    clearTally();
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    checkOutput("idle", 0, 0, 0, 0, 0, 0);
  endtask

  // Drive one instruction from its wait-cycle schedule; a delay of TMO or
  // more on a handshake means the core must give up and report a bus error.
  task automatic runInstr(input int kind, input int da, input int dr, input int la, input int lr,
                          input bit rf_dec, input bit junk, input logic [31:0] npc,
                          input logic [31:0] rdata, output bit stopped);
    bit mem;
    mem = (kind == K_LOAD) || (kind == K_STORE);
    stopped = 0;
    clearTally();
    for (int k = 0; k <= da && k < TMO; k++) begin
      scrambleDecode();
      applyStimulus(k == da, junk && (k == da), ~rdata, 0, 0);
      checkOutput("fetch", 1, 0, 0, 0, 0);
    end
    if (da >= TMO) begin model_err = 1; stopped = 1; checkStopped("fetch_err", 3); return; end
    for (int k = 0; k <= dr && k < TMO; k++) begin
      scrambleDecode();
      applyStimulus(1'($urandom), k == dr, (k == dr) ? rdata : $urandom, 0, 0);
      checkOutput("iwait", 0, 1, 0, 0, 0);
    end
    if (dr >= TMO) begin model_err = 1; stopped = 1; checkStopped("iwait_err", 3); return; end
    model_inst = rdata;
    setDecode(kind, rf_dec, npc);
    applyStimulus(0, 1'($urandom), $urandom, 0, 0);
    checkOutput("exec", 0, 0, 0, 0, 0);
    if (mem) begin
      for (int k = 0; k <= la && k < TMO; k++) begin
        applyStimulus(0, 1'($urandom), $urandom, k == la, 0);
        checkOutput("mreq", 0, 0, 1, 0, 0);
      end
      if (la >= TMO) begin model_err = 1; stopped = 1; checkStopped("mreq_err", 3); return; end
      for (int k = 0; k <= lr && k < TMO; k++) begin
        applyStimulus(0, 1'($urandom), $urandom, 0, k == lr);
        checkOutput("mwait", 0, 0, 0, 0, 0);
      end
      if (lr >= TMO) begin model_err = 1; stopped = 1; checkStopped("mwait_err", 3); return; end
    end
    applyStimulus(0, 1'($urandom), $urandom, 0, 0);
    checkOutput("wb", 0, 0, 0, kind != K_EBRK, rf_dec && (kind != K_STORE));
    if (kind != K_EBRK) begin
      model_pc = npc;
    end else begin
      model_halted = 1;
      stopped = 1;
      checkStopped("halt", 3);
    end
  endtask

  function automatic int rdelay();
    return ($urandom_range(0, 49) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
  endfunction

  // Directed table, reset/abort sequence, randomized runs, summary.
  initial begin
    vec_t tbl[8];
    bit   stopped;
    tbl[0] = '{K_ALU,   0, 0, 0, 0, 1, 0, 32'h8000_0004, 32'h0010_0093,  4, 1, 1, 0};
    tbl[1] = '{K_LOAD,  0, 0, 3, 1, 1, 0, 32'h8000_0004, 32'h0000_a103, 10, 1, 1, 4};
    tbl[2] = '{K_STORE, 0, 0, 0, 0, 1, 0, 32'h8000_0004, 32'h0020_a023,  6, 0, 1, 1};
    tbl[3] = '{K_ALU,  10, 0, 0, 0, 1, 0, 32'h8000_0004, 32'h0010_0093,  0, 0, 0, 0};
    tbl[4] = '{K_EBRK,  0, 0, 0, 0, 0, 0, 32'h8000_0004, 32'h0010_0073,  4, 0, 0, 0};
    tbl[5] = '{K_LOAD,  3, 3, 3, 3, 1, 1, 32'hffff_fffc, 32'h0040_a183, 18, 1, 1, 4};
    tbl[6] = '{K_STORE, 0, 0, 0, 5, 1, 0, 32'h8000_0004, 32'h0020_a023,  0, 0, 0, 1};
    tbl[7] = '{K_ALU,   0, 4, 0, 0, 1, 0, 32'h8000_0004, 32'h0010_0093,  0, 0, 0, 0};

    rst = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0);
    setDecode(K_ALU, 0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      applyReset();
      runInstr(tbl[i].kind, tbl[i].da, tbl[i].dr, tbl[i].la, tbl[i].lr, tbl[i].rf_dec,
               tbl[i].junk, tbl[i].npc, tbl[i].rdata, stopped);
      checkCounts($sformatf("table%0d", i), tbl[i].e_wb, tbl[i].e_rf, tbl[i].e_pcwe, tbl[i].e_lsuv);
    end

    // Reset pulled in MWAIT must abort the load and restart from RESET_PC.
    applyReset();
    runInstr(K_ALU, 0, 0, 0, 0, 1, 0, 32'h1234_5678, 32'h0010_0093, stopped);
    clearTally();
    applyStimulus(1, 0, 32'h0, 0, 0);
    checkOutput("abort_fetch", 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'h0000_a103, 0, 0);
    checkOutput("abort_iwait", 0, 1, 0, 0, 0, 2);
    model_inst = 32'h0000_a103;
    setDecode(K_LOAD, 1, 32'h1234_567c);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkOutput("abort_exec", 0, 0, 0, 0, 0, 3);
    applyStimulus(0, 0, 32'h0, 1, 0);
    checkOutput("abort_mreq", 0, 0, 1, 0, 0, 4);
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkOutput("abort_mwait", 0, 0, 0, 0, 0, 5);
    applyStimulus(0, 0, 32'h0, 0, 1);
    rst = 1'b0;
    model_pc = RST_PC; model_inst = NOP;
    checkOutput("abort_rst", 0, 0, 0, 0, 0, 0);
    checkOutput("abort_rst_hold", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0);
    checkOutput("abort_idle", 0, 0, 0, 0, 0, 0);
    checkOutput("abort_refetch", 1, 0, 0, 0, 0, 1);

    // Randomized runs of up to eight instructions each.
    for (int run = 0; run < 25; run++) begin
      applyReset();
      stopped = 0;
      for (int n = 0; n < 8 && !stopped; n++) begin
        int  r, kind, da, dr, la, lr, e_wb, e_lsuv;
        bit  mem, err, rf_dec;
        r = $urandom_range(0, 19);
        kind = (r < 1) ? K_EBRK : (r < 6) ? K_LOAD : (r < 10) ? K_STORE : K_ALU;
        da = rdelay(); dr = rdelay(); la = rdelay(); lr = rdelay();
        mem = (kind == K_LOAD) || (kind == K_STORE);
        rf_dec = (kind == K_EBRK) ? 1'b0 : 1'($urandom);
        err = (da >= TMO) || (dr >= TMO) || (mem && ((la >= TMO) || (lr >= TMO)));
        e_wb = err ? 0 : da + dr + 4 + (mem ? la + lr + 2 : 0);
        e_lsuv = (mem && da < TMO && dr < TMO) ? ((la < TMO) ? la + 1 : TMO) : 0;
        runInstr(kind, da, dr, la, lr, rf_dec, 1'($urandom), $urandom, $urandom, stopped);
        checkCounts($sformatf("rand%0d_%0d", run, n), e_wb,
                    (!err && rf_dec && kind != K_STORE) ? 1 : 0,
                    (!err && kind != K_EBRK) ? 1 : 0, e_lsuv);
      end
    end

`ifdef YSYX_CORE_SEQ_PERF_EN
    // Three zero-wait ALU instructions: 4 busy cycles each.
    applyReset();
    for (int i = 0; i < 3; i++)
      runInstr(K_ALU, 0, 0, 0, 0, 1, 0, model_pc + 32'd4, 32'h0010_0093, stopped);
    checks++;
    if (perf_instret !== 64'd3 || perf_cycle !== 64'd12) begin
      failures++;
      $display("[TB] FAIL perf actual cycle=%0d instret=%0d required cycle=12 instret=3",
               perf_cycle, perf_instret);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
